// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle for seq_restoring_divider: operands in, results and status out.
interface seq_restoring_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIV_EARLY_EXIT_EN finishes dividend < divisor operations one cycle after accept.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam int PR_W  = DIVISOR_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dvd_q;  // dividend bits leave at the top, quotient bits enter at the bottom
  logic [DIVISOR_W-1:0]  dvs;
  logic [PR_W-1:0]       pr;
  logic [PR_W-1:0]       pr_shift;
  logic [PR_W-1:0]       pr_nxt;
  logic                  q_bit;
  logic                  accept;
  logic                  div_zero;
  logic                  early;
  logic                  last_iter;
  logic [DIVIDEND_W-1:0] quotient_r;
  logic [DIVISOR_W-1:0]  remainder_r;
  logic                  dbz_r;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    early     = 1'b0;
    div_zero  = (bus.divisor == '0);
    last_iter = (cnt == CNT_W'(DIVIDEND_W - 1));
    pr_shift  = {pr[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    q_bit     = (pr_shift >= {1'b0, dvs});
    pr_nxt    = q_bit ? (pr_shift - {1'b0, dvs}) : pr_shift;
`ifdef DIV_EARLY_EXIT_EN
    early     = (bus.dividend < DIVIDEND_W'(bus.divisor));
`else
    early     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (div_zero || early) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible results: reset clears them, results only change at accept or the final iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        if (div_zero) begin
          quotient_r  <= '1;
          remainder_r <= '0;
          dbz_r       <= 1'b1;
        end else begin
          dbz_r <= 1'b0;
          if (early) begin
            quotient_r  <= '0;
            remainder_r <= bus.dividend[DIVISOR_W-1:0];
          end
        end
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          quotient_r  <= {dvd_q[DIVIDEND_W-2:0], q_bit};
          remainder_r <= pr_nxt[DIVISOR_W-1:0];
        end
      end
    end
  end

  // Working datapath: loaded on accept, iterated in CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q <= bus.dividend;
      dvs   <= bus.divisor;
      pr    <= '0;
    end else if (state == CALC) begin
      pr    <= pr_nxt;
      dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit};
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential unsigned restoring divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor -> quotient + remainder.
- Inverse of the team's combinational 4x4 array multiplier; recovers operands from products (8-bit / 4-bit by default).
- One quotient bit per clock; start/busy/done handshake toward the surrounding TT user-module logic.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width (>= DIVISOR_W).
- DIVISOR_W, 4, divisor and remainder width (>= 2).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  DIVIDEND_W  numerator, captured on the accepting edge.
- divisor  in  DIVISOR_W  denominator, captured on the accepting edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  DIVIDEND_W  result, held until the next accept.
- remainder  out  DIVISOR_W  result, held until the next accept.
- div_by_zero  out  1  error flag for the last operation, held until the next accept.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; iteration counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE->CALC: start=1 and divisor!=0. Captures both operands, clears partial remainder (DIVISOR_W+1 bits internally), counter=0.
- IDLE->DONE (divide-by-zero): start=1 and divisor==0. quotient=all ones, remainder=0, div_by_zero=1.
- CALC, per edge, MSB-first:
  - shift the next dividend bit into the partial remainder (PR);
  - if PR >= divisor: PR -= divisor, quotient bit = 1; else quotient bit = 0 (restore);
  - counter++. After DIVIDEND_W iterations go to DONE; remainder = low DIVISOR_W bits of PR.
- DONE: done=1 for exactly one cycle, then DONE->IDLE unconditionally.
- Latency, normal case: done is high in the cycle after the DIVIDEND_W-th edge following the accepting edge, i.e. 8 cycles by default.
- Latency, divide-by-zero: done high in the cycle after the accepting edge (1 cycle).
- Handshake:
  - start ignored in CALC and DONE; no queuing.
  - start held high re-arms: accepted again on the first IDLE cycle.
  - Operand inputs may change freely after the accepting edge.
- Outputs:
  - quotient/remainder are updated only at the end of the operation. Intermediate values are never visible; the previous results stay stable through CALC.
  - div_by_zero clears on the next accept with a nonzero divisor.
- Arithmetic: unsigned only; remainder < divisor always; quotient*divisor+remainder == dividend for divisor!=0.
- Reset mid-operation: aborts immediately, all outputs return to reset values, no done pulse.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined:
  - on accept with divisor!=0 and dividend < divisor: IDLE->DONE directly with quotient=0, remainder=dividend[DIVISOR_W-1:0], done 1 cycle after accept;
  - when dividend==0: quotient=0, remainder=0, 1-cycle latency.
- Undefined: these cases take the full DIVIDEND_W-cycle path with identical final results.

Test Plan:
- 200/7: start for one cycle -> busy high for 9 cycles (8 CALC + 1 DONE); done pulse 8 cycles after accept; quotient=28 (0x1C), remainder=4, div_by_zero=0.
- 255/15 then 0xE1/15 back-to-back with start held high -> quotient=17, remainder=0; then quotient=15, remainder=0. Second accept on the first IDLE cycle after done.
- 13/0 -> done 1 cycle after accept; quotient=0xFF, remainder=0, div_by_zero=1. Next op 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- 5/9:
  - without the macro: done at cycle 8, quotient=0, remainder=5;
  - with DIV_EARLY_EXIT_EN: same result, done at cycle 1.
- Start 100/6 (expect quotient=16, remainder=4). During CALC, pulse start with 50/5 and change operands -> first result unaffected; second start ignored; only one done pulse.
- Start 200/7; assert rst_n=0 at cycle 4 -> outputs 0 asynchronously, no done. Release, run 60/4 -> quotient=15, remainder=0.
